// File: rtl/sbp_update_ctrl.sv
// Stage-RAM update controller: buffers write commands, replays them onto the shared
// port-B write bus and holds off after each update until in-flight lookups drain.
module sbp_update_ctrl #(
  parameter int NUM_STAGES    = 32,
  parameter int ADDR_BITS     = 11,
  parameter int DATA_BITS     = 64,
  parameter int STAGE_ID_BITS = 6,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [STAGE_ID_BITS-1:0] cmd_stage_id,
  input  logic [ADDR_BITS-1:0]     cmd_addr,
  input  logic [DATA_BITS-1:0]     cmd_data,
  input  logic                     cmd_last,
  output logic [NUM_STAGES-1:0]    wr_en,
  output logic [ADDR_BITS-1:0]     wr_addr,
  output logic [DATA_BITS-1:0]     wr_data,
  output logic                     busy,
  output logic                     done_o,
  output logic                     err_o,
  output logic [15:0]              update_cnt
);

  localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS   = PTR_BITS + 1;
  localparam int DRAIN_BITS = $clog2(NUM_STAGES) + 1;

  typedef struct packed {
    logic [STAGE_ID_BITS-1:0] stage_id;
    logic [ADDR_BITS-1:0]     addr;
    logic [DATA_BITS-1:0]     data;
    logic                     last;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  cmd_t                  mem [FIFO_DEPTH];
  cmd_t                  cmd_in;
  cmd_t                  head;
  logic [PTR_BITS-1:0]   wr_ptr;
  logic [PTR_BITS-1:0]   rd_ptr;
  logic [CNT_BITS-1:0]   count;
  logic [CNT_BITS-1:0]   count_nxt;
  logic                  push;
  logic                  pop;
  logic                  head_ok;
  logic [NUM_STAGES-1:0] stage_dec;

  state_t                state;
  state_t                state_nxt;
  logic [DRAIN_BITS-1:0] drain_cnt;
  logic [DRAIN_BITS-1:0] drain_cnt_nxt;
  logic                  drain_done;

  assign cmd_in    = '{stage_id: cmd_stage_id, addr: cmd_addr, data: cmd_data, last: cmd_last};
  assign head      = mem[rd_ptr];
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state != DRAIN) && (count != '0);
  assign count_nxt = count + CNT_BITS'(push) - CNT_BITS'(pop);
  assign head_ok   = 32'(head.stage_id) < NUM_STAGES;
  assign busy      = (count != '0) || (state != IDLE);

  // Command buffer; ready is registered from the next occupancy so it never
  // depends combinationally on cmd_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count     <= count_nxt;
      cmd_ready <= count_nxt < CNT_BITS'(FIFO_DEPTH);
    end
  end

  always_comb begin
    stage_dec = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      stage_dec[i] = (32'(head.stage_id) == i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // DRAIN covers the final write cycle and the NUM_STAGES-1 cycles after it, so
  // the pop that follows lands its write NUM_STAGES+1 cycles after that write.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    drain_done    = 1'b0;
    case (state)
      IDLE, ISSUE: begin
        if (pop && head.last) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRAIN_BITS'(NUM_STAGES - 1);
        end else begin
          state_nxt = (count_nxt != '0) ? ISSUE : IDLE;
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          drain_done = 1'b1;
          state_nxt  = (count_nxt != '0) ? ISSUE : IDLE;
        end else begin
          drain_cnt_nxt = drain_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en      <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      err_o      <= 1'b0;
      done_o     <= 1'b0;
      update_cnt <= '0;
    end else begin
      wr_en  <= '0;
      err_o  <= 1'b0;
      done_o <= drain_done;
      if (pop) begin
        if (head_ok) begin
          wr_en   <= stage_dec;
          wr_addr <= head.addr;
          wr_data <= head.data;
        end else begin
          err_o <= 1'b1;
        end
      end
      if (done_o) begin
        update_cnt <= update_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sbp_update_ctrl.sv
// Directed self-checking bench for sbp_update_ctrl with default parameters.
module tb_sbp_update_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_stage_id;
  logic [10:0] cmd_addr;
  logic [63:0] cmd_data;
  logic        cmd_last;
  logic [31:0] wr_en;
  logic [10:0] wr_addr;
  logic [63:0] wr_data;
  logic        busy;
  logic        done_o;
  logic        err_o;
  logic [15:0] update_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [31:0] en;
    logic [10:0] addr;
    logic [63:0] data;
  } wrec_t;

  typedef struct {
    logic [5:0]  stage;
    logic [10:0] addr;
    logic [63:0] data;
    logic        last;
  } tcmd_t;

  typedef struct {
    logic [5:0]  stage;
    logic [10:0] addr;
    logic [63:0] data;
    logic [31:0] exp_en;
    logic        exp_err;
    logic [10:0] exp_addr;
    logic [63:0] exp_data;
  } vec_t;

  wrec_t wq[$];
  int    dq[$];
  int    eq[$];
  tcmd_t bq[$];

  sbp_update_ctrl #(
    .NUM_STAGES   (32),
    .ADDR_BITS    (11),
    .DATA_BITS    (64),
    .STAGE_ID_BITS(6),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_stage_id(cmd_stage_id),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_last    (cmd_last),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done_o      (done_o),
    .err_o       (err_o),
    .update_cnt  (update_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en != '0) wq.push_back('{cyc, wr_en, wr_addr, wr_data});
    if (done_o) dq.push_back(cyc);
    if (err_o) eq.push_back(cyc);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wq.delete();
    dq.delete();
    eq.delete();
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      step();
      n++;
    end
    check("idle_reached", busy, 0);
    step();
    step();
  endtask

  // Offers one command and returns the cycle number of the accepting edge.
  task automatic send(input logic [5:0] s, input logic [10:0] a, input logic [63:0] d,
                      input logic l, output int k);
    int n = 0;
    cmd_valid    = 1'b1;
    cmd_stage_id = s;
    cmd_addr     = a;
    cmd_data     = d;
    cmd_last     = l;
    while (!cmd_ready && n < 200) begin
      step();
      n++;
    end
    check("send_ready", cmd_ready, 1);
    step();
    k         = cyc;
    cmd_valid = 1'b0;
  endtask

  // Streams bq with cmd_valid held; low_at is the number accepted when ready first fell.
  task automatic run_burst(output int low_at);
    int   acc = 0;
    int   n   = 0;
    logic rdy;
    low_at = -1;
    while (acc < bq.size() && n < 300) begin
      cmd_valid    = 1'b1;
      cmd_stage_id = bq[acc].stage;
      cmd_addr     = bq[acc].addr;
      cmd_data     = bq[acc].data;
      cmd_last     = bq[acc].last;
      rdy          = cmd_ready;
      if (!rdy && low_at < 0) low_at = acc;
      step();
      if (rdy) acc++;
      n++;
    end
    cmd_valid = 1'b0;
    check("burst_all_accepted", acc, bq.size());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, cmd_ready, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_cnt"}, update_cnt, 0);
  endtask

  vec_t vt[7];

  initial begin
    int k;
    int low_at;
    int u0;

    vt[0] = '{6'd3,  11'h010, 64'hA5A5,                 32'h0000_0008, 1'b0, 11'h010, 64'hA5A5};
    vt[1] = '{6'd0,  11'h7FF, 64'hFFFF_FFFF_FFFF_FFFF,  32'h0000_0001, 1'b0, 11'h7FF, 64'hFFFF_FFFF_FFFF_FFFF};
    vt[2] = '{6'd31, 11'h001, 64'h0123_4567_89AB_CDEF,  32'h8000_0000, 1'b0, 11'h001, 64'h0123_4567_89AB_CDEF};
    vt[3] = '{6'd32, 11'h155, 64'hDEAD,                 32'h0000_0000, 1'b1, 11'h001, 64'h0123_4567_89AB_CDEF};
    vt[4] = '{6'd63, 11'h2AA, 64'h1,                    32'h0000_0000, 1'b1, 11'h001, 64'h0123_4567_89AB_CDEF};
    vt[5] = '{6'd16, 11'h400, 64'h8000_0000_0000_0000,  32'h0001_0000, 1'b0, 11'h400, 64'h8000_0000_0000_0000};
    vt[6] = '{6'd40, 11'h3C3, 64'h77,                   32'h0000_0000, 1'b1, 11'h400, 64'h8000_0000_0000_0000};

    rst          = 1'b0;
    cmd_valid    = 1'b0;
    cmd_stage_id = '0;
    cmd_addr     = '0;
    cmd_data     = '0;
    cmd_last     = 1'b0;

    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();
    check("ready_after_reset", cmd_ready, 1);
    check("busy_after_reset", busy, 0);

    // Single non-final commands into an idle block.
    foreach (vt[i]) begin
      send(vt[i].stage, vt[i].addr, vt[i].data, 1'b0, k);
      step();
      check($sformatf("vec%0d_wr_en", i), wr_en, vt[i].exp_en);
      check($sformatf("vec%0d_wr_addr", i), wr_addr, vt[i].exp_addr);
      check($sformatf("vec%0d_wr_data", i), wr_data, vt[i].exp_data);
      check($sformatf("vec%0d_err", i), err_o, vt[i].exp_err);
      check($sformatf("vec%0d_done", i), done_o, 0);
      step();
      check($sformatf("vec%0d_en_off", i), wr_en, 0);
      check($sformatf("vec%0d_addr_hold", i), wr_addr, vt[i].exp_addr);
      check($sformatf("vec%0d_data_hold", i), wr_data, vt[i].exp_data);
      check($sformatf("vec%0d_idle", i), busy, 0);
    end
    check("nonlast_cnt", update_cnt, 0);

    // Single final command: latency 1, done 32 cycles after the write.
    clear_mon();
    send(6'd3, 11'h010, 64'hA5A5, 1'b1, k);
    wait_idle(200);
    check("single_writes", wq.size(), 1);
    check("single_done_count", dq.size(), 1);
    if (wq.size() > 0) begin
      check("single_wr_cycle", wq[0].cyc, k + 1);
      check("single_wr_en", wq[0].en, 32'h0000_0008);
      check("single_wr_addr", wq[0].addr, 11'h010);
      check("single_wr_data", wq[0].data, 64'hA5A5);
    end
    if (dq.size() > 0) check("single_done_cycle", dq[0], k + 1 + 32);
    check("single_cnt", update_cnt, 1);

    // Buffer fills during a drain, then six commands replay back to back.
    clear_mon();
    u0 = int'(update_cnt);
    send(6'd5, 11'h050, 64'h55, 1'b1, k);
    bq.delete();
    for (int i = 0; i < 6; i++) bq.push_back('{6'(10 + i), 11'(11'h200 + i), 64'hC0DE_0000 + 64'(i), i == 5});
    run_burst(low_at);
    check("fill_ready_low_at", low_at, 4);
    wait_idle(300);
    check("fill_writes", wq.size(), 7);
    check("fill_done_count", dq.size(), 2);
    if (wq.size() == 7 && dq.size() == 2) begin
      check("fill_first_write", wq[0].cyc, k + 1);
      check("fill_done0", dq[0], k + 33);
      check("fill_resume", wq[1].cyc, dq[0] + 1);
      for (int i = 0; i < 6; i++) begin
        check($sformatf("fill%0d_cycle", i), wq[1 + i].cyc, wq[1].cyc + i);
        check($sformatf("fill%0d_en", i), wq[1 + i].en, 32'd1 << bq[i].stage);
        check($sformatf("fill%0d_addr", i), wq[1 + i].addr, bq[i].addr);
        check($sformatf("fill%0d_data", i), wq[1 + i].data, bq[i].data);
      end
      check("fill_done1", dq[1], wq[6].cyc + 32);
    end
    check("fill_cnt", update_cnt, 16'(u0 + 2));

    // Two updates of two commands in one burst.
    clear_mon();
    u0 = int'(update_cnt);
    bq.delete();
    bq.push_back('{6'd1, 11'h300, 64'h1, 1'b0});
    bq.push_back('{6'd2, 11'h301, 64'h2, 1'b1});
    bq.push_back('{6'd3, 11'h302, 64'h3, 1'b0});
    bq.push_back('{6'd4, 11'h303, 64'h4, 1'b1});
    run_burst(low_at);
    check("two_ready_stayed_high", low_at, -1);
    wait_idle(300);
    check("two_writes", wq.size(), 4);
    check("two_done_count", dq.size(), 2);
    if (wq.size() == 4 && dq.size() == 2) begin
      check("two_w1_w0_gap", wq[1].cyc - wq[0].cyc, 1);
      check("two_w2_w1_gap", wq[2].cyc - wq[1].cyc, 33);
      check("two_w3_w2_gap", wq[3].cyc - wq[2].cyc, 1);
      check("two_done0", dq[0], wq[1].cyc + 32);
      check("two_done1", dq[1], wq[3].cyc + 32);
      for (int i = 0; i < 4; i++) check($sformatf("two%0d_addr", i), wq[i].addr, bq[i].addr);
    end
    check("two_cnt", update_cnt, 16'(u0 + 2));

    // Out-of-range final command still completes an update.
    clear_mon();
    u0 = int'(update_cnt);
    send(6'd40, 11'h0AB, 64'h99, 1'b1, k);
    wait_idle(200);
    check("err_no_writes", wq.size(), 0);
    check("err_pulses", eq.size(), 1);
    check("err_done_count", dq.size(), 1);
    if (eq.size() == 1) check("err_cycle", eq[0], k + 1);
    if (dq.size() == 1) check("err_done_cycle", dq[0], k + 33);
    check("err_addr_held", wr_addr, 11'h303);
    check("err_cnt", update_cnt, 16'(u0 + 1));

    // Counter wrap from 0xFFFF.
    force dut.update_cnt = 16'hFFFF;
    #1;
    release dut.update_cnt;
    step();
    check("wrap_preload", update_cnt, 16'hFFFF);
    clear_mon();
    send(6'd6, 11'h060, 64'h6, 1'b1, k);
    wait_idle(200);
    check("wrap_done_count", dq.size(), 1);
    check("wrap_cnt", update_cnt, 16'h0000);

    // Reset mid-drain with two commands buffered.
    clear_mon();
    send(6'd2, 11'h020, 64'h2, 1'b1, k);
    send(6'd7, 11'h070, 64'h7, 1'b0, k);
    send(6'd8, 11'h080, 64'h8, 1'b0, k);
    step();
    step();
    check("pre_reset_busy", busy, 1);
    check("pre_reset_writes", wq.size(), 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    step();
    check_reset_outputs("midreset_edge");
    rst = 1'b1;
    clear_mon();
    for (int i = 0; i < 60; i++) step();
    check("post_reset_writes", wq.size(), 0);
    check("post_reset_done", dq.size(), 0);
    check("post_reset_err", eq.size(), 0);
    check("post_reset_ready", cmd_ready, 1);
    check("post_reset_busy", busy, 0);
    check("post_reset_cnt", update_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sbp_update_ctrl.md
SBP_UPDATE_CTRL -- requirements
Module: sbp_update_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 32: number of lookup stages and stage RAMs.
REQ-002 SHALL have parameter ADDR_BITS, default 11: stage RAM address width.
REQ-003 SHALL have parameter DATA_BITS, default 64: stage RAM word width.
REQ-004 SHALL have parameter STAGE_ID_BITS, default 6: stage identifier width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4 (power of two, at least 2): command buffer entries.
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port cmd_valid  input  1  write command offered.
REQ-009 SHALL have port cmd_ready  output  1  command buffer can accept.
REQ-010 SHALL have port cmd_stage_id  input  STAGE_ID_BITS  target stage RAM.
REQ-011 SHALL have port cmd_addr  input  ADDR_BITS  target word address.
REQ-012 SHALL have port cmd_data  input  DATA_BITS  word to write.
REQ-013 SHALL have port cmd_last  input  1  final write of one update.
REQ-014 SHALL have port wr_en  output  NUM_STAGES  one-hot port-B write enable, bit i to stage RAM i.
REQ-015 SHALL have port wr_addr  output  ADDR_BITS  port-B address, shared by all stage RAMs.
REQ-016 SHALL have port wr_data  output  DATA_BITS  port-B data, shared by all stage RAMs.
REQ-017 SHALL have port busy  output  1  buffer non-empty or FSM not IDLE.
REQ-018 SHALL have port done_o  output  1  one-cycle pulse when an update is committed.
REQ-019 SHALL have port err_o  output  1  one-cycle pulse when an out-of-range stage_id is dropped.
REQ-020 SHALL have port update_cnt  output  16  committed-update counter.

Function
REQ-021 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both high.
REQ-022 SHALL drive cmd_ready high exactly when buffer occupancy is below FIFO_DEPTH, using registered state only.
REQ-023 SHALL, on simultaneous push and pop, leave occupancy unchanged and keep commands in order, including when occupancy is FIFO_DEPTH.
REQ-024 SHALL implement the FSM states IDLE, ISSUE and DRAIN.
REQ-025 SHALL, in IDLE or ISSUE with a non-empty buffer, pop the head command on each edge.
REQ-026 SHALL register all write outputs.
REQ-027 SHALL hold wr_en high for exactly one cycle per popped command.
REQ-028 SHALL give a latency of 1: a command accepted at edge k into an empty buffer while IDLE drives wr_en in cycle k+1; the pop happens at edge k+1 and wr_en is visible after it.
REQ-029 SHALL sustain one write per cycle while the buffer is non-empty and no DRAIN is pending.
REQ-030 SHALL drive wr_en to zero and hold wr_addr and wr_data at their last values whenever no write is issued.
REQ-031 SHALL, for a popped command with cmd_stage_id >= NUM_STAGES, assert no wr_en bit and pulse err_o in the cycle its write would have appeared.
REQ-032 SHALL, after the write cycle T of a command with cmd_last=1 (valid or erroneous), enter DRAIN.
REQ-033 SHALL pop no command during DRAIN, while still accepting commands into the buffer.
REQ-034 SHALL pulse done_o high only in cycle T+NUM_STAGES, so in-flight lookups fully drain before the next update starts.
REQ-035 SHALL increment update_cnt by 1 at the end of cycle T+NUM_STAGES, wrapping from 0xFFFF to 0.
REQ-036 SHALL issue the earliest following write in cycle T+NUM_STAGES+1.
REQ-037 SHALL return the FSM to IDLE when the buffer is empty and no DRAIN is active; otherwise it SHALL stay in ISSUE.
REQ-038 SHALL, for a command without cmd_last, not change update_cnt and not pulse done_o.

Reset
REQ-039 SHALL, while rst is low, force these outputs: cmd_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done_o=0, err_o=0, update_cnt=0; buffer empty, FSM IDLE, drain counter 0.
REQ-040 SHALL make cmd_ready high in the first cycle after rst is released.
REQ-041 SHALL, on reset asserted mid-update or mid-DRAIN, discard buffered commands immediately and pulse neither done_o nor wr_en.

Verification
REQ-042 SHALL cover: single command (stage 3, addr 0x10, data 0xA5A5, last=1) into idle block -> wr_en=0x00000008 in cycle k+1; done_o in cycle k+1+32; update_cnt=1.
REQ-043 SHALL cover: 6 back-to-back commands, last only on the 6th, with cmd_valid held high -> cmd_ready low once 4 are buffered; 6 consecutive write cycles in order; one done_o.
REQ-044 SHALL cover: two updates of 2 commands each, sent in one burst -> writes 3-4 start no earlier than 33 cycles after write 2; two done_o pulses; update_cnt=2.
REQ-045 SHALL cover: command with stage_id 40, last=1 -> no wr_en, err_o pulse, done_o 32 cycles later, update_cnt increments.
REQ-046 SHALL cover: rst low for 1 cycle during DRAIN with 2 commands buffered -> all outputs zero, no done_o, no later writes from discarded commands.
REQ-047 SHALL cover: update_cnt preloaded to 0xFFFF by 65535 updates (or forced) plus one more update -> update_cnt=0x0000.
